// File: rtl/id_issue_buf_pkg.sv
// id_issue_buf_pkg: shared sizing constants and helpers for the decode-to-issue buffer.
package id_issue_buf_pkg;

    // Core-level defaults for the decode-to-issue buffer instantiation.
    localparam int unsigned IdBufDepth    = 2;
    localparam int unsigned IdMaxCtrlFlow = 1;

    // Pointer width for a modulo-depth pointer; a single-entry buffer still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/id_issue_buf_ptr.sv
// id_issue_buf_ptr: modulo-Depth wrapping pointer with increment and synchronous clear.
module id_issue_buf_ptr
    import id_issue_buf_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned PtrW  = ptr_width(Depth)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [PtrW-1:0] ptr_o
);

    logic [PtrW-1:0] ptr_q, ptr_d;

    // Explicit wrap at Depth-1 so non-power-of-two depths work.
    always_comb begin
        ptr_d = clr_i ? '0 :
                inc_i ? ((ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + 1'b1) :
                ptr_q;
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/id_issue_buf.sv
// id_issue_buf: in-order decode-to-issue buffer with control-flow throttling and atomic flush.
// Optional same-cycle bypass when empty is enabled by defining ID_BYPASS_EN.
module id_issue_buf
    import id_issue_buf_pkg::*;
#(
    parameter int unsigned DataWidth   = 128,
    parameter int unsigned Depth       = IdBufDepth,
    parameter int unsigned MaxCtrlFlow = IdMaxCtrlFlow,
    parameter int unsigned CountW      = $clog2(Depth + 1),
    parameter int unsigned CfW         = $clog2(MaxCtrlFlow + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_ctrl_flow_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_ctrl_flow_o,
    output logic                 out_valid_o,
    input  logic                 out_ack_i,
    output logic [CountW-1:0]    count_o,
    output logic [CfW-1:0]       cf_count_o
);

    localparam int unsigned PtrW = ptr_width(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [Depth-1:0]     cf_q;
    logic [CountW-1:0]    count_q, count_d;
    logic [CfW-1:0]       cf_count_q, cf_count_d;
    logic [PtrW-1:0]      rd_ptr, wr_ptr;
    logic                 byp, pop, push, wr, rd, cf_block;

`ifdef ID_BYPASS_EN
    assign byp = (count_q == '0) && in_valid_i && !flush_i;
`else
    assign byp = 1'b0;
`endif

    // Handshakes and head selection; a bypassed-and-acked entry never touches storage.
    always_comb begin
        out_valid_o     = !flush_i && ((count_q != '0) || byp);
        out_data_o      = byp ? in_data_i : mem_q[rd_ptr];
        out_ctrl_flow_o = byp ? in_ctrl_flow_i : cf_q[rd_ptr];
        pop             = out_ack_i && out_valid_o;
        cf_block        = in_ctrl_flow_i && (cf_count_q == CfW'(MaxCtrlFlow)) && !(pop && out_ctrl_flow_o);
        in_ready_o      = !flush_i && ((count_q < CountW'(Depth)) || pop) && !cf_block;
        push            = in_valid_i && in_ready_o;
        wr              = push && !(byp && pop);
        rd              = pop && !byp;
        count_d         = flush_i ? '0 : count_q + CountW'(wr) - CountW'(rd);
        cf_count_d      = flush_i ? '0 : cf_count_q + CfW'(wr && in_ctrl_flow_i) - CfW'(rd && out_ctrl_flow_o);
    end

    // Occupancy and control-flow counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            cf_count_q <= '0;
        end else begin
            count_q    <= count_d;
            cf_count_q <= cf_count_d;
        end
    end

    // Entry storage, cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            cf_q  <= '0;
        end else if (wr) begin
            mem_q[wr_ptr] <= in_data_i;
            cf_q[wr_ptr]  <= in_ctrl_flow_i;
        end
    end

    id_issue_buf_ptr #(.Depth(Depth)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush_i),
        .inc_i (rd),
        .ptr_o (rd_ptr)
    );

    id_issue_buf_ptr #(.Depth(Depth)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush_i),
        .inc_i (wr),
        .ptr_o (wr_ptr)
    );

    assign count_o    = count_q;
    assign cf_count_o = cf_count_q;

`ifndef SYNTHESIS
    // Simulation-only check: the issue stage must not ack an empty head (flush hides valid).
    ack_without_valid: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_ack_i && !out_valid_o && !flush_i))
        else $error("out_ack_i asserted without out_valid_o");
`endif

endmodule

// File: tb/tb_id_issue_buf.sv
// tb_id_issue_buf: randomized and directed checks of id_issue_buf against a queue model.
module tb_id_issue_buf;

    localparam int DEPTH = 3;
    localparam int MAXCF = 1;
    localparam int DW    = 32;
`ifdef ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic          cf;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_cf = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_cf;
    logic          out_valid;
    logic          ack = 1'b0;
    logic [1:0]    count;
    logic [0:0]    cf_count;

    int   n_chk = 0;
    int   n_err = 0;
    ent_t q[$];

    id_issue_buf #(.DataWidth(DW), .Depth(DEPTH), .MaxCtrlFlow(MAXCF)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush),
        .in_data_i       (in_data),
        .in_ctrl_flow_i  (in_cf),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .out_data_o      (out_data),
        .out_ctrl_flow_o (out_cf),
        .out_valid_o     (out_valid),
        .out_ack_i       (ack),
        .count_o         (count),
        .cf_count_o      (cf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: model predicts outputs from queue contents, then advances.
    task automatic cycle(input bit iv, input bit icf, input logic [DW-1:0] id, input bit ack_req, input bit fl);
        int   ncf;
        bit   byp, ev, pop, er;
        ent_t h, e;
        @(negedge clk);
        in_valid = iv;
        in_cf    = icf;
        in_data  = id;
        flush    = fl;
        ncf = 0;
        foreach (q[i]) ncf += int'(q[i].cf);
        e.cf = icf;
        e.d  = id;
        byp = BYP && q.size() == 0 && iv && !fl;
        ev  = !fl && (q.size() != 0 || byp);
        h   = byp ? e : (q.size() != 0 ? q[0] : '0);
        ack = ack_req && (ev || fl);
        pop = ack && ev;
        er  = !fl && (q.size() < DEPTH || pop) && !(icf && ncf == MAXCF && !(pop && h.cf));
        #1;
        chk("valid", 64'(out_valid), 64'(ev));
        chk("ready", 64'(in_ready), 64'(er));
        chk("count", 64'(count), 64'(q.size()));
        chk("cf_count", 64'(cf_count), 64'(ncf));
        if (ev) begin
            chk("data", 64'(out_data), 64'(h.d));
            chk("ctrl_flow", 64'(out_cf), 64'(h.cf));
        end
        @(posedge clk);
        if (fl) q.delete();
        else if (!(byp && pop)) begin
            if (pop) void'(q.pop_front());
            if (iv && er) q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_cf_count"}, 64'(cf_count), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_ctrl_flow"}, 64'(out_cf), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        // Fill to Depth, fourth push stalls, then pop-and-push on a full buffer.
        cycle(1, 0, 32'hA, 0, 0);
        cycle(1, 0, 32'hB, 0, 0);
        cycle(1, 0, 32'hC, 0, 0);
        cycle(1, 0, 32'hD, 0, 0);
        cycle(1, 0, 32'hD, 1, 0);
        repeat (4) cycle(0, 0, 0, 1, 0);
        // Control-flow throttle: second CF stalls until the first is acked.
        cycle(1, 1, 32'hC1, 0, 0);
        cycle(1, 1, 32'hC2, 0, 0);
        cycle(1, 1, 32'hC2, 1, 0);
        repeat (2) cycle(0, 0, 0, 1, 0);
        // Flush with simultaneous push and ack.
        cycle(1, 0, 32'h1, 0, 0);
        cycle(1, 0, 32'h2, 0, 0);
        cycle(1, 0, 32'h77, 1, 1);
        cycle(0, 0, 0, 0, 0);
        // Sustained push/pop exercises pointer wrap on a non-power-of-two depth.
        for (int k = 1; k <= 10; k++) cycle(1, 0, DW'(k), k > 1, 0);
        repeat (2) cycle(0, 0, 0, 1, 0);
        // Push into an empty buffer with ack held (bypass when enabled).
        cycle(1, 0, 32'h55, 1, 0);
        cycle(0, 0, 0, 1, 0);
        // Asynchronous reset while holding two entries.
        cycle(1, 1, 32'h11, 0, 0);
        cycle(1, 0, 32'h22, 0, 0);
        @(negedge clk);
        in_valid = 0;
        in_cf    = 0;
        ack      = 0;
        flush    = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        // Randomized traffic.
        repeat (600)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, DW'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
